// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES gamepad reader.
// SNES_ACTIVE_LOW_EN (see snes_controller) is not referenced here.
package snes_pkg;

    localparam int unsigned SNES_NUM_BITS = 16;
    localparam int unsigned SNES_BTN_BITS = 12;

    // Bit positions in the button word, in serial shift order.
    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSlotLo,
        StSlotHi,
        StCommit
    } snes_state_e;

    function automatic int unsigned snes_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/snes_sync.sv
// Two-flop synchronizer for the pad's serial data line; resets to the idle-high level.
module snes_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/snes_controller.sv
// SNES gamepad reader: periodic latch, 16 serial clocks, registered 12-bit button word.
// Define SNES_ACTIVE_LOW_EN to store inverted samples (pressed button reads as 1).
module snes_controller
    import snes_pkg::*;
#(
    parameter int unsigned LATCH_CYCLES = 300,
    parameter int unsigned HALF_CYCLES  = 150,
    parameter int unsigned POLL_CYCLES  = 416_667
) (
    input  logic                     clk_25M,
    input  logic                     rst,
    input  logic                     SNES_Data,
    output logic                     SNES_Latch,
    output logic                     SNES_clk_1,
    output logic [SNES_BTN_BITS-1:0] btn_output
);

    localparam int unsigned SlotMax = snes_max(LATCH_CYCLES, HALF_CYCLES);
    localparam int unsigned CntW    = snes_max($clog2(SlotMax), 1);
    localparam int unsigned PollW   = snes_max($clog2(POLL_CYCLES), 1);
    localparam int unsigned IdxW    = $clog2(SNES_NUM_BITS);

    localparam logic [CntW-1:0]  LatchLast = CntW'(LATCH_CYCLES - 1);
    localparam logic [CntW-1:0]  HalfLast  = CntW'(HALF_CYCLES - 1);
    localparam logic [PollW-1:0] PollLast  = PollW'(POLL_CYCLES - 1);
    localparam logic [IdxW-1:0]  IdxLast   = IdxW'(SNES_NUM_BITS - 1);

    snes_state_e              state_q;
    logic                     start_q;
    logic [PollW-1:0]         poll_q;
    logic [CntW-1:0]          cnt_q;
    logic [IdxW-1:0]          idx_q;
    logic [SNES_NUM_BITS-1:0] shift_q;
    logic                     latch_q;
    logic                     sclk_q;
    logic [SNES_BTN_BITS-1:0] btn_q;

    logic                     data_sync;
    logic [SNES_BTN_BITS-1:0] commit_word;
    logic                     unused_shift_hi;

    snes_sync u_sync (
        .clk_i (clk_25M),
        .rst_i (rst),
        .d_i   (SNES_Data),
        .q_o   (data_sync)
    );

`ifdef SNES_ACTIVE_LOW_EN
    assign commit_word = ~shift_q[SNES_BTN_BITS-1:0];
`else
    assign commit_word = shift_q[SNES_BTN_BITS-1:0];
`endif

    // Bits 12..15 are shifted in to keep the pad's framing but never reported.
    assign unused_shift_hi = ^shift_q[SNES_NUM_BITS-1:SNES_BTN_BITS];

    always_ff @(posedge clk_25M) begin
        if (rst) begin
            state_q <= StIdle;
            start_q <= 1'b1;
            poll_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            latch_q <= 1'b0;
            sclk_q  <= 1'b1;
            btn_q   <= '0;
        end else begin
            // Saturates so a short poll period restarts right after COMMIT.
            if (poll_q != PollLast) begin
                poll_q <= poll_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start_q || (poll_q == PollLast)) begin
                        state_q <= StLatch;
                        start_q <= 1'b0;
                        poll_q  <= '0;
                        cnt_q   <= '0;
                        latch_q <= 1'b1;
                    end
                end

                StLatch: begin
                    if (cnt_q == LatchLast) begin
                        state_q <= StSlotLo;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        latch_q <= 1'b0;
                        sclk_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StSlotLo: begin
                    if (cnt_q == HalfLast) begin
                        shift_q[idx_q] <= data_sync;
                        state_q        <= StSlotHi;
                        cnt_q          <= '0;
                        sclk_q         <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StSlotHi: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q <= '0;
                        if (idx_q == IdxLast) begin
                            state_q <= StCommit;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= StSlotLo;
                            sclk_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StCommit: begin
                    btn_q   <= commit_word;
                    state_q <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign SNES_Latch = latch_q;
    assign SNES_clk_1 = sclk_q;
    assign btn_output = btn_q;

    a_latch_clk_excl: assert property (@(posedge clk_25M) disable iff (rst)
        !(latch_q && !sclk_q));

    a_btn_commit_only: assert property (@(posedge clk_25M) disable iff (rst)
        (state_q != StCommit) |=> $stable(btn_q));

endmodule

// File: tb/tb_snes_controller.sv
// Self-checking bench for snes_controller: behavioural pad model plus frame-timing monitor.
// Honours SNES_ACTIVE_LOW_EN when computing expected button words.
module tb_snes_controller;

    localparam int unsigned LATCH = 20;
    localparam int unsigned HALF  = 8;
    localparam int unsigned POLL  = 600;
    localparam int unsigned FRAME = LATCH + 32 * HALF + 1;

    logic        clk_25M = 1'b0;
    logic        rst;
    logic        SNES_Data;
    logic        SNES_Latch;
    logic        SNES_clk_1;
    logic [11:0] btn_output;

    snes_controller #(
        .LATCH_CYCLES (LATCH),
        .HALF_CYCLES  (HALF),
        .POLL_CYCLES  (POLL)
    ) dut (
        .clk_25M    (clk_25M),
        .rst        (rst),
        .SNES_Data  (SNES_Data),
        .SNES_Latch (SNES_Latch),
        .SNES_clk_1 (SNES_clk_1),
        .btn_output (btn_output)
    );

    always #5 clk_25M = ~clk_25M;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] plan [10];
    int          frame_num = 0;
    logic [15:0] cur_pat = '0;
    int          bit_idx = 16;
    logic        prev_latch = 1'b0;
    logic        prev_sclk  = 1'b1;
    logic [11:0] prev_btn   = '0;
    int          cyc = 0;
    int          latch_rise_cyc = -1;
    int          fall_cyc = 0;
    int          pulses = 0;
    bit          frame_active = 1'b0;
    logic [11:0] hold_btn = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pad reports bit k as the k-th serial level; the word keeps bits 0..11.
    function automatic logic [11:0] exp_word(input logic [15:0] p);
`ifdef SNES_ACTIVE_LOW_EN
        return ~p[11:0];
`else
        return p[11:0];
`endif
    endfunction

    // One cycle: observe at negedge, run monitor and pad model, then drive data.
    task automatic step();
        @(negedge clk_25M);
        cyc++;
        if (rst) begin
            frame_active   = 1'b0;
            latch_rise_cyc = -1;
            hold_btn       = '0;
            bit_idx        = 16;
        end else begin
            if (SNES_Latch && !prev_latch) begin
                if (latch_rise_cyc >= 0)
                    check_eq("latch_period", 32'(cyc - latch_rise_cyc), 32'(POLL));
                if (frame_active) begin
                    check_eq("pulse_count", 32'(pulses), 32'(16));
                    check_eq("btn_frame", 32'(btn_output), 32'(exp_word(cur_pat)));
                    hold_btn = exp_word(cur_pat);
                end
                cur_pat        = plan[frame_num % 10];
                frame_num++;
                latch_rise_cyc = cyc;
                pulses         = 0;
                frame_active   = 1'b1;
                bit_idx        = 0;
            end
            if (!SNES_Latch && prev_latch) begin
                check_eq("latch_width", 32'(cyc - latch_rise_cyc), 32'(LATCH));
                check_eq("btn_hold", 32'(btn_output), 32'(hold_btn));
            end
            if (!SNES_clk_1 && prev_sclk) begin
                pulses++;
                fall_cyc = cyc;
                if (pulses == 1)
                    check_eq("first_fall_at_latch_fall", 32'(prev_latch && !SNES_Latch), 32'(1));
            end
            if (SNES_clk_1 && !prev_sclk) begin
                check_eq("clk_low_width", 32'(cyc - fall_cyc), 32'(HALF));
                bit_idx++;
            end
            if (btn_output != prev_btn) begin
                check_eq("btn_update_value", 32'(btn_output), 32'(exp_word(cur_pat)));
                check_eq("btn_update_time", 32'(cyc - latch_rise_cyc), 32'(FRAME));
            end
        end
        prev_latch = SNES_Latch;
        prev_sclk  = SNES_clk_1;
        prev_btn   = btn_output;
        SNES_Data  = (bit_idx < 16) ? cur_pat[bit_idx] : 1'b1;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_num < target && n < budget) begin
            step();
            n++;
        end
        check_eq("frames_reached", 32'(frame_num), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_latch"}, 32'(SNES_Latch), 32'(0));
        check_eq({tag, "_sclk"}, 32'(SNES_clk_1), 32'(1));
        check_eq({tag, "_btn"}, 32'(btn_output), 32'(0));
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        SNES_Data = 1'b1;
        plan[0] = 16'h05C9;  // 1,0,0,1,0,0,1,1,1,0,1,0,0,0,0,0
        plan[1] = 16'h048E;  // 0,1,1,1,0,0,0,1,0,0,1,0,0,0,0,0
        plan[2] = 16'($urandom);
        plan[3] = 16'($urandom);
        plan[4] = 16'hFFFF;
        plan[5] = 16'h0000;
        plan[6] = 16'($urandom);
        plan[7] = ~plan[6];
        plan[8] = 16'($urandom);
        plan[9] = 16'($urandom);

        repeat (10) step();
        check_reset_outputs("rst_hold");

        rst = 1'b0;
        step();
        check_eq("latch_after_rst", 32'(SNES_Latch), 32'(1));

        // Six complete frames; each is scored at the following latch rise.
        wait_frames(7, 7 * int'(POLL) + 100);

        // Abort during slot 5 (sixth low pulse).
        n = 0;
        while (pulses < 6 && n < int'(FRAME)) begin
            step();
            n++;
        end
        check_eq("slot5_reached", 32'(pulses), 32'(6));
        repeat (3) step();
        rst = 1'b1;
        step();
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        step();
        check_eq("latch_after_mid_rst", 32'(SNES_Latch), 32'(1));
        wait_frames(frame_num + 1, int'(POLL) + 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
